prg_loader: RTL and testbench

Monitor-side loader that owns the program port of the CDECv memory. It parses a byte-stream command protocol arriving from the monitor's UART receiver and turns each command into write/read cycles on prg_we/prg_MA/prg_WD/prg_RD. It returns acknowledge or read-data bytes to the UART transmitter. It sits between the UART pair and the memory's program port; prg_clock is tied externally to the same clock as this block.

---
 rtl/monitor_pkg.sv | 25 ++
 rtl/prg_loader.sv | 179 +++++++++++++++++
 tb/tb_prg_loader.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_pkg.sv
// Shared definitions for the monitor-side program loader: protocol bytes and FSM states.
package monitor_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_COUNT,
        ST_GET_DATA,
        ST_WRITE,
        ST_READ_WAIT,
        ST_SEND
    } state_e;

    function automatic logic is_known_cmd(input logic [7:0] b);
        return (b == CMD_W) || (b == CMD_R) || (b == CMD_L) || (b == CMD_D);
    endfunction

endpackage

// File: rtl/prg_loader.sv
// Byte-stream command parser driving the memory program port (W/R/L/D commands)
// and returning ACK/NAK or read data to the UART transmitter.
module prg_loader
    import monitor_pkg::*;
#(
    parameter int unsigned RD_LATENCY     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD,
    output logic       busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      RD_LAST = 2'(RD_LATENCY);

    state_e          state_q;
    logic [7:0]      cmd_q;
    logic [7:0]      addr_q;
    logic [8:0]      count_q;
    logic [1:0]      rd_cnt_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            prg_we_q;
    logic [7:0]      prg_ma_q;
    logic [7:0]      prg_wd_q;
    logic [7:0]      tx_data_q;
    logic            tx_valid_q;

    logic in_get;
    logic to_expired;

    assign in_get     = (state_q == ST_GET_ADDR) || (state_q == ST_GET_COUNT) ||
                        (state_q == ST_GET_DATA);
    assign to_expired = in_get && !rx_valid && (to_cnt_q == TO_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 8'h00;
            addr_q     <= 8'h00;
            count_q    <= 9'd0;
            rd_cnt_q   <= 2'd0;
            to_cnt_q   <= '0;
            prg_we_q   <= 1'b0;
            prg_ma_q   <= 8'h00;
            prg_wd_q   <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            // NOTE: a default non-blocking assignment followed by a later one in the
            // same block is legal; the last assignment wins, giving a one-cycle strobe.
            prg_we_q <= 1'b0;

            // Idle timer only runs while waiting for operand bytes.
            if (in_get && !rx_valid) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end else begin
                to_cnt_q <= '0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd_q   <= rx_data;
                        count_q <= 9'd1;
                        if (is_known_cmd(rx_data)) begin
                            state_q <= ST_GET_ADDR;
                        end else begin
                            tx_data_q  <= NAK;
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end
                    end
                end

                ST_GET_ADDR: begin
                    if (to_expired) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        addr_q <= rx_data;
                        if (cmd_q == CMD_W) begin
                            state_q <= ST_GET_DATA;
                        end else if (cmd_q == CMD_R) begin
                            prg_ma_q <= rx_data;
                            rd_cnt_q <= 2'd0;
                            state_q  <= ST_READ_WAIT;
                        end else begin
                            state_q <= ST_GET_COUNT;
                        end
                    end
                end

                ST_GET_COUNT: begin
                    if (to_expired) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        count_q <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        if (cmd_q == CMD_D) begin
                            prg_ma_q <= addr_q;
                            rd_cnt_q <= 2'd0;
                            state_q  <= ST_READ_WAIT;
                        end else begin
                            state_q <= ST_GET_DATA;
                        end
                    end
                end

                ST_GET_DATA: begin
                    if (to_expired) begin
                        state_q <= ST_IDLE;
                    end else if (rx_valid) begin
                        prg_ma_q <= addr_q;
                        prg_wd_q <= rx_data;
                        prg_we_q <= 1'b1;
                        state_q  <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    addr_q  <= addr_q + 8'd1;
                    count_q <= count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        tx_data_q  <= ACK;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end else begin
                        state_q <= ST_GET_DATA;
                    end
                end

                ST_READ_WAIT: begin
                    if (rd_cnt_q == RD_LAST) begin
                        tx_data_q  <= prg_RD;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_SEND;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 2'd1;
                    end
                end

                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        // A dump continues with the next address; everything else ends here.
                        if ((cmd_q == CMD_D) && (count_q != 9'd1)) begin
                            count_q  <= count_q - 9'd1;
                            addr_q   <= addr_q + 8'd1;
                            prg_ma_q <= addr_q + 8'd1;
                            rd_cnt_q <= 2'd0;
                            state_q  <= ST_READ_WAIT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign prg_we   = prg_we_q;
    assign prg_MA   = prg_ma_q;
    assign prg_WD   = prg_wd_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: command-level reference model, memory model on the
// program port, and a per-cycle compare of write strobes and transmitted bytes.
module tb_prg_loader;
    import monitor_pkg::*;

    localparam int RDL = 2;
    localparam int TO  = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD;
    logic       busy;

    prg_loader #(.RD_LATENCY(RDL), .TIMEOUT_CYCLES(TO)) dut (
        .clock   (clock),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .prg_we  (prg_we),
        .prg_MA  (prg_MA),
        .prg_WD  (prg_WD),
        .prg_RD  (prg_RD),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    // Program-port memory with an RDL-stage read pipeline.
    logic [7:0] mem      [256];
    logic [7:0] fill_pat [256];
    logic [7:0] rd_pipe  [RDL];
    logic       fill_en = 1'b0;

    always @(posedge clock) begin
        if (fill_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= fill_pat[i];
        end else if (prg_we) begin
            mem[prg_MA] <= prg_WD;
        end
        rd_pipe[0] <= mem[prg_MA];
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign prg_RD = rd_pipe[RDL-1];

    // Reference model state and expectations.
    logic [7:0] ref_mem [256];
    logic [7:0] exp_wa[$];
    logic [7:0] exp_wd[$];
    logic [7:0] exp_tx[$];
    logic [7:0] ldata[$];

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the test

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic gap(input bit gaps);
        if (gaps) idle($urandom_range(0, 2));
    endtask

    // Issue one full command; expectations are derived from command semantics.
    task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] n,
                           input logic [7:0] wdata, input bit gaps);
        int cnt;
        logic [7:0] d;
        logic [7:0] ad;
        logic [7:0] bytes[$];
        cnt = (n == 8'h00) ? 256 : int'(n);
        if (c == CMD_W) begin
            exp_wa.push_back(a); exp_wd.push_back(wdata);
            ref_mem[a] = wdata;
            exp_tx.push_back(ACK);
        end else if (c == CMD_R) begin
            exp_tx.push_back(ref_mem[a]);
        end else if (c == CMD_L) begin
            for (int i = 0; i < cnt; i++) begin
                d  = (ldata.size() != 0) ? ldata.pop_front() : 8'($urandom);
                ad = 8'(int'(a) + i);
                bytes.push_back(d);
                exp_wa.push_back(ad); exp_wd.push_back(d);
                ref_mem[ad] = d;
            end
            exp_tx.push_back(ACK);
        end else if (c == CMD_D) begin
            for (int i = 0; i < cnt; i++) exp_tx.push_back(ref_mem[8'(int'(a) + i)]);
        end else begin
            exp_tx.push_back(NAK);
        end

        send_byte(c);
        if (!is_known_cmd(c)) return;
        gap(gaps);
        send_byte(a);
        if (c == CMD_W) begin
            gap(gaps);
            send_byte(wdata);
        end else if (c == CMD_L || c == CMD_D) begin
            gap(gaps);
            send_byte(n);
            for (int i = 0; i < bytes.size(); i++) begin
                if (i != 0) begin
                    idle(1);
                    gap(gaps);
                end
                send_byte(bytes[i]);
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            idle(1);
            k++;
        end
        check("idle_reached", int'(busy), 0);
        check("tx_pending", exp_tx.size(), 0);
        check("wr_pending", exp_wa.size(), 0);
    endtask

    task automatic wait_tx_valid(input int budget);
        int k = 0;
        while (!tx_valid && k < budget) begin
            idle(1);
            k++;
        end
        check("tx_valid_arrives", int'(tx_valid), 1);
    endtask

    // tx_ready driver for the automatic modes.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (ready_mode == 0) tx_ready = 1'b1;
            else if (ready_mode == 1) tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle compare of write strobes, transmitted bytes and handshake stability.
    logic       prev_stall = 1'b0;
    logic       prev_we    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_tx.delete(); exp_wa.delete(); exp_wd.delete();
                prev_stall = 1'b0;
                prev_we    = 1'b0;
            end else begin
                if (prg_we) begin
                    check("we_single_cycle", int'(prev_we), 0);
                    if (exp_wa.size() == 0) begin
                        check("unexpected_write", 1, 0);
                    end else begin
                        check("write_addr", int'(prg_MA), int'(exp_wa.pop_front()));
                        check("write_data", int'(prg_WD), int'(exp_wd.pop_front()));
                    end
                end
                if (prev_stall) begin
                    check("tx_hold_valid", int'(tx_valid), 1);
                    check("tx_hold_data", int'(tx_data), int'(prev_data));
                end
                if (tx_valid && tx_ready) begin
                    hs_count++;
                    if (exp_tx.size() == 0) check("unexpected_tx", 1, 0);
                    else check("tx_byte", int'(tx_data), int'(exp_tx.pop_front()));
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_we    = prg_we;
            end
        end
    end

    initial begin
        int hs0;
        logic [7:0] c;

        for (int i = 0; i < 256; i++) begin
            fill_pat[i] = 8'($urandom);
            ref_mem[i]  = fill_pat[i];
        end

        // Reset state, memory preload during reset.
        fill_en = 1'b1;
        idle(2);
        fill_en = 1'b0;
        idle(1);
        check("rst_prg_we", int'(prg_we), 0);
        check("rst_prg_MA", int'(prg_MA), 0);
        check("rst_prg_WD", int'(prg_WD), 0);
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        idle(2);

        // W 0x10 0xA5: strobe one cycle after the data byte, ACK the cycle after.
        run_cmd(CMD_W, 8'h10, 8'h00, 8'hA5, 1'b0);
        check("w_strobe", int'(prg_we), 1);
        check("w_addr", int'(prg_MA), 8'h10);
        check("w_data", int'(prg_WD), 8'hA5);
        idle(1);
        check("w_strobe_drop", int'(prg_we), 0);
        check("w_ack_valid", int'(tx_valid), 1);
        check("w_ack_byte", int'(tx_data), 8'h06);
        wait_idle(50);

        // R 0x10: address next cycle, data RDL+1 cycles after that.
        run_cmd(CMD_R, 8'h10, 8'h00, 8'h00, 1'b0);
        check("r_addr", int'(prg_MA), 8'h10);
        idle(2);
        check("r_not_early", int'(tx_valid), 0);
        idle(1);
        check("r_valid", int'(tx_valid), 1);
        check("r_byte", int'(tx_data), 8'hA5);
        wait_idle(50);

        // L 0xFE 3 with address wrap.
        ldata = '{8'h11, 8'h22, 8'h33};
        run_cmd(CMD_L, 8'hFE, 8'h03, 8'h00, 1'b0);
        wait_idle(100);
        check("l_mem_fe", int'(mem[8'hFE]), 8'h11);
        check("l_mem_ff", int'(mem[8'hFF]), 8'h22);
        check("l_mem_00", int'(mem[8'h00]), 8'h33);

        // D 0xFE 3 with a 5-cycle stall on every byte.
        ready_mode = 2;
        tx_ready   = 1'b0;
        run_cmd(CMD_D, 8'hFE, 8'h03, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_tx_valid(50);
            idle(5);
            tx_ready = 1'b1;
            idle(1);
            tx_ready = 1'b0;
        end
        ready_mode = 0;
        wait_idle(50);

        // D 0x00 0x00: 256 bytes, random backpressure.
        ready_mode = 1;
        hs0 = hs_count;
        run_cmd(CMD_D, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_idle(8000);
        check("d256_count", hs_count - hs0, 256);

        // Unknown command: NAK; bytes during pending SEND are dropped.
        ready_mode = 2;
        tx_ready   = 1'b0;
        run_cmd(8'h41, 8'h00, 8'h00, 8'h00, 1'b0);
        check("nak_valid", int'(tx_valid), 1);
        check("nak_byte", int'(tx_data), 8'h15);
        send_byte(CMD_W);
        send_byte(8'h30);
        send_byte(8'h77);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        check("nak_busy_low", int'(busy), 0);
        check("nak_tx_drop", int'(tx_valid), 0);
        idle(3);
        check("nak_dropped_bytes", int'(busy), 0);
        ready_mode = 0;
        wait_idle(10);

        // Timeout while waiting for W data; no write, no response.
        send_byte(CMD_W);
        send_byte(8'h20);
        idle(90);
        check("to_still_busy", int'(busy), 1);
        idle(20);
        check("to_back_idle", int'(busy), 0);
        check("to_no_tx", int'(tx_valid), 0);
        run_cmd(CMD_W, 8'h20, 8'h00, 8'h5A, 1'b0);
        wait_idle(50);
        check("to_w_after", int'(mem[8'h20]), 8'h5A);

        // Reset in the middle of L 0x40 4 after two data bytes.
        exp_wa.push_back(8'h40); exp_wd.push_back(8'hC1); ref_mem[8'h40] = 8'hC1;
        exp_wa.push_back(8'h41); exp_wd.push_back(8'hC2); ref_mem[8'h41] = 8'hC2;
        send_byte(CMD_L);
        send_byte(8'h40);
        send_byte(8'h04);
        send_byte(8'hC1);
        idle(1);
        send_byte(8'hC2);
        idle(1);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_we", int'(prg_we), 0);
        check("mid_rst_MA", int'(prg_MA), 0);
        check("mid_rst_WD", int'(prg_WD), 0);
        check("mid_rst_tx_valid", int'(tx_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        idle(3);
        reset = 1'b0;
        idle(5);
        check("rst_kept_40", int'(mem[8'h40]), 8'hC1);
        check("rst_kept_41", int'(mem[8'h41]), 8'hC2);
        check("rst_untouched_42", int'(mem[8'h42]), int'(ref_mem[8'h42]));
        check("rst_no_ack", int'(tx_valid), 0);
        check("rst_idle", int'(busy), 0);

        // Randomized command mix with random gaps and backpressure.
        ready_mode = 1;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0, 1:    c = CMD_W;
                2, 3:    c = CMD_R;
                4, 5, 6: c = CMD_L;
                7, 8:    c = CMD_D;
                default: begin
                    c = 8'($urandom);
                    while (is_known_cmd(c)) c = 8'($urandom);
                end
            endcase
            run_cmd(c, 8'($urandom), 8'($urandom_range(1, 6)), 8'($urandom), 1'b1);
            wait_idle(1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
